instr_fetch: RTL and testbench

Instruction fetch unit that generates the program counter, reads 32-bit instruction words from instruction memory over a request/acknowledge handshake, and presents each word to the instruction decoder with a valid/ready handshake. It sits between the instruction memory port and the Controler decode stage. It accepts redirects (branch/jump targets) from execute and flags misaligned targets.

---
 rtl/instr_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_fetch.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC generation, imem request/ack fetch, valid/ready hand-off to decode.
// Redirects during an outstanding request are deferred via a drop flag; misaligned targets fault.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        fault
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StReq, StHold, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        drop_q, drop_d;
  // Request still outstanding after entering FAULT; bus has no cancellation.
  logic        busy_q, busy_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;

  logic redir_ok, redir_bad;
  assign redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      drop_q       <= 1'b0;
      busy_q       <= 1'b0;
      instr_q      <= Nop;
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    drop_d       = drop_q;
    busy_d       = busy_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    fault_d      = fault_q;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (redir_ok) begin
          fetch_pc_d = redirect_pc;
        end else if (redir_bad) begin
          state_d = StFault;
          fault_d = 1'b1;
        end
      end
      StReq: begin
        if (redir_bad) begin
          state_d = StFault;
          fault_d = 1'b1;
          drop_d  = 1'b0;
          busy_d  = !imem_ack;
        end else if (imem_ack) begin
          drop_d = 1'b0;
          if (redir_ok) begin
            fetch_pc_d = redirect_pc;
          end else if (drop_q) begin
            fetch_pc_d = pending_pc_q;
          end else begin
            instr_d = imem_rdata;
            pc_d    = fetch_pc_q;
            state_d = StHold;
          end
        end else if (redir_ok) begin
          // Address must stay stable; remember the target until the ack arrives.
          drop_d       = 1'b1;
          pending_pc_d = redirect_pc;
        end
      end
      StHold: begin
        if (redir_bad) begin
          state_d = StFault;
          fault_d = 1'b1;
        end else if (redir_ok) begin
          fetch_pc_d = redirect_pc;
          state_d    = StReq;
        end else if (instr_ready) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = StReq;
        end
      end
      StFault: begin
        if (imem_ack) begin
          busy_d = 1'b0;
        end
        if (redir_ok) begin
          fault_d = 1'b0;
          state_d = StReq;
          busy_d  = 1'b0;
          if (busy_q && !imem_ack) begin
            drop_d       = 1'b1;
            pending_pc_d = redirect_pc;
          end else begin
            fetch_pc_d = redirect_pc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign imem_req    = (state_q == StReq) || ((state_q == StFault) && busy_q);
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (state_q == StHold);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch: one record per clock cycle with
// the inputs driven in that cycle and the outputs expected before the next edge.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc),
    .fault       (fault)
  );

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] einstr;
    logic [31:0] epc;
    logic        efault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic ack, input logic [31:0] rdata,
                              input logic redir, input logic [31:0] rpc, input logic ready,
                              input logic ereq, input logic [31:0] eaddr, input logic evalid,
                              input logic [31:0] einstr, input logic [31:0] epc,
                              input logic efault);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.ready = ready;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.einstr = einstr; v.epc = epc;
    v.efault = efault;
    return v;
  endfunction

  // Called at posedge+1: drive the cycle's inputs, check at negedge, advance one edge.
  task automatic step(input string tag, input vec_t v);
    reset       = v.rst;
    imem_ack    = v.ack;
    imem_rdata  = v.rdata;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    instr_ready = v.ready;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== v.ereq || imem_addr !== v.eaddr || instr_valid !== v.evalid ||
        instr !== v.einstr || pc !== v.epc || fault !== v.efault) begin
      n_bad++;
      $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h pc=%h fault=%b; want req=%b addr=%h valid=%b instr=%h pc=%h fault=%b",
               tag, imem_req, imem_addr, instr_valid, instr, pc, fault,
               v.ereq, v.eaddr, v.evalid, v.einstr, v.epc, v.efault);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] R = 32'h8000_0000;
  localparam logic [31:0] N = 32'h0000_0013;

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0;

    //                rst ack rdata         rd rpc           rdy  req addr           vld instr          pc             flt
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0,   0, R,              0, N,             R,             0));
    vecs.push_back(mk(1, 1, 32'h0050_0093, 0, 32'h0,         0,   1, R,              0, N,             R,             0));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,         1,   0, R,              1, 32'h0050_0093, R,             0));
    vecs.push_back(mk(1, 1, 32'h00A0_0113, 0, 32'h0,         0,   1, 32'h8000_0004,  0, 32'h0050_0093, R,             0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 32'h0,       0, 32'h0,         0,   0, 32'h8000_0004,  1, 32'h00A0_0113, 32'h8000_0004, 0));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,         1,   0, 32'h8000_0004,  1, 32'h00A0_0113, 32'h8000_0004, 0));
    vecs.push_back(mk(1, 0, 32'h0,         1, 32'h8000_0100, 0,   1, 32'h8000_0008,  0, 32'h00A0_0113, 32'h8000_0004, 0));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h8000_0008,  0, 32'h00A0_0113, 32'h8000_0004, 0));
    vecs.push_back(mk(1, 1, 32'hDEAD_BEEF, 0, 32'h0,         0,   1, 32'h8000_0008,  0, 32'h00A0_0113, 32'h8000_0004, 0));
    vecs.push_back(mk(1, 1, 32'h0020_81B3, 0, 32'h0,         0,   1, 32'h8000_0100,  0, 32'h00A0_0113, 32'h8000_0004, 0));
    vecs.push_back(mk(1, 0, 32'h0,         1, 32'h8000_0102, 0,   0, 32'h8000_0100,  1, 32'h0020_81B3, 32'h8000_0100, 0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 0, 32'h0,       0, 32'h0,         1,   0, 32'h8000_0100,  0, 32'h0020_81B3, 32'h8000_0100, 1));
    vecs.push_back(mk(1, 0, 32'h0,         1, 32'h8000_0200, 0,   0, 32'h8000_0100,  0, 32'h0020_81B3, 32'h8000_0100, 1));
    vecs.push_back(mk(1, 1, 32'h0000_A023, 0, 32'h0,         0,   1, 32'h8000_0200,  0, 32'h0020_81B3, 32'h8000_0100, 0));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,         1,   0, 32'h8000_0200,  1, 32'h0000_A023, 32'h8000_0200, 0));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) step($sformatf("vec%0d", i), vecs[i]);

    // Redirect coinciding with ack, then misaligned redirect with a request in flight.
    step("redir_ack",    mk(1, 1, 32'hBAD0_BAD0, 1, 32'h8000_0300, 0, 1, 32'h8000_0204, 0, 32'h0000_A023, 32'h8000_0200, 0));
    step("req_after_ra", mk(1, 1, 32'h1111_1111, 0, 32'h0,         0, 1, 32'h8000_0300, 0, 32'h0000_A023, 32'h8000_0200, 0));
    step("hold_ra",      mk(1, 0, 32'h0,         0, 32'h0,         1, 0, 32'h8000_0300, 1, 32'h1111_1111, 32'h8000_0300, 0));
    step("bad_inflight", mk(1, 0, 32'h0,         1, 32'h8000_0305, 0, 1, 32'h8000_0304, 0, 32'h1111_1111, 32'h8000_0300, 0));
    step("fault_busy0",  mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8000_0304, 0, 32'h1111_1111, 32'h8000_0300, 1));
    step("fault_busy1",  mk(1, 1, 32'h2222_2222, 0, 32'h0,         0, 1, 32'h8000_0304, 0, 32'h1111_1111, 32'h8000_0300, 1));
    step("fault_quiet",  mk(1, 0, 32'h0,         1, 32'h8000_0400, 0, 0, 32'h8000_0304, 0, 32'h1111_1111, 32'h8000_0300, 1));
    // Reset lands on the same edge as an ack.
    step("rst_with_ack", mk(0, 1, 32'h3333_3333, 0, 32'h0,         0, 1, 32'h8000_0400, 0, 32'h1111_1111, 32'h8000_0300, 0));
    step("after_rst",    mk(1, 0, 32'h0,         0, 32'h0,         0, 0, R,             0, N,             R,             0));
    // Pending target overwritten, then PC wraps past 0xFFFF_FFFC.
    step("pend_first",   mk(1, 0, 32'h0,         1, 32'h9000_0000, 0, 1, R,             0, N,             R,             0));
    step("pend_over",    mk(1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 1, R,             0, N,             R,             0));
    step("pend_ack",     mk(1, 1, 32'h4444_4444, 0, 32'h0,         0, 1, R,             0, N,             R,             0));
    step("req_top",      mk(1, 1, 32'h5555_5555, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, N,             R,             0));
    step("hold_top",     mk(1, 0, 32'h0,         0, 32'h0,         1, 0, 32'hFFFF_FFFC, 1, 32'h5555_5555, 32'hFFFF_FFFC, 0));
    step("wrap",         mk(1, 1, 32'h6666_6666, 0, 32'h0,         0, 1, 32'h0000_0000, 0, 32'h5555_5555, 32'hFFFF_FFFC, 0));
    // Redirect beats a simultaneous ready in HOLD.
    step("hold_redir",   mk(1, 0, 32'h0,         1, 32'h8000_0010, 1, 0, 32'h0000_0000, 1, 32'h6666_6666, 32'h0000_0000, 0));
    step("after_hr",     mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8000_0010, 0, 32'h6666_6666, 32'h0000_0000, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
